// File: rtl/uart_cmd_assembler.sv
// Receive-side command assembler: pairs two UART bytes (high, then low) into a 16-bit command.
// Optional inter-byte timeout that drops a stale high byte: define CMD_RX_TIMEOUT_EN.

module uart #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);
    localparam int unsigned BW = $clog2(BAUD_DIV);

    logic          rx_meta_q, rx_sync_q;
    logic          rx_busy_q;
    logic [BW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_rdy_q;
    logic [7:0]    rx_data_q;

    logic          tx_busy_q;
    logic [BW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    // 8N1 receiver: sample mid-bit; rx_rdy is a level held until cleared (new byte wins over clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= BW'(BAUD_DIV / 2);
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q == '0) begin
                rx_cnt_q <= BW'(BAUD_DIV - 1);
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= 1'b1;
                    rx_data_q <= rx_shift_q;
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q - BW'(1);
            end
        end
    end

    // 8N1 transmitter; trmt is ignored while a frame is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_done_q  <= 1'b0;
        end else if (!tx_busy_q) begin
            if (trmt) begin
                tx_busy_q  <= 1'b1;
                tx_shift_q <= {1'b1, tx_data, 1'b0};
                tx_cnt_q   <= BW'(BAUD_DIV - 1);
                tx_bit_q   <= '0;
                tx_done_q  <= 1'b0;
            end
        end else if (tx_cnt_q == '0) begin
            tx_cnt_q <= BW'(BAUD_DIV - 1);
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_done_q <= 1'b1;
            end else begin
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q - BW'(1);
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;
endmodule

module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 130000,
    parameter int unsigned TO_W           = 18,
    parameter int unsigned BAUD_DIV       = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic        cmd_rdy,
    output logic [15:0] cmd,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done,
    output logic        frame_err
);
    typedef enum logic {HIGH_WAIT, LOW_WAIT} state_e;

    if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy_c;

    state_e      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
`ifdef CMD_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            frame_err_q, frame_err_d;
`endif

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .TX        (TX),
        .trmt      (trmt),
        .tx_data   (resp),
        .tx_done   (tx_done),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .clr_rx_rdy(clr_rx_rdy_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HIGH_WAIT;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
`ifdef CMD_RX_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Byte pairing; frame completion sets cmd_rdy ahead of the consumer's clear
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q & ~clr_cmd_rdy;
        clr_rx_rdy_c = 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
`endif
        case (state_q)
            HIGH_WAIT: begin
                if (rx_rdy) begin
                    clr_rx_rdy_c = 1'b1;
                    hi_d         = rx_data;
                    cmd_rdy_d    = 1'b0;
                    state_d      = LOW_WAIT;
`ifdef CMD_RX_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            LOW_WAIT: begin
                if (rx_rdy) begin
                    clr_rx_rdy_c = 1'b1;
                    cmd_d        = {hi_q, rx_data};
                    cmd_rdy_d    = 1'b1;
                    state_d      = HIGH_WAIT;
                end
`ifdef CMD_RX_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    hi_d        = '0;
                    frame_err_d = 1'b1;
                    state_d     = HIGH_WAIT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
`ifdef CMD_RX_TIMEOUT_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: byte pairing, cmd_rdy handshake, reset, timeout, TX framing.
module tb_uart_cmd_assembler;
    localparam int unsigned BAUD = 16;
`ifdef CMD_RX_TIMEOUT_EN
    localparam int unsigned EXP_FERR = 1;
    localparam logic [15:0] EXP_CMD  = 16'h0A0B;
    localparam logic        EXP_RDY  = 1'b1;
`else
    localparam int unsigned EXP_FERR = 0;
    localparam logic [15:0] EXP_CMD  = 16'h550A;
    localparam logic        EXP_RDY  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, tx_done, frame_err;
    logic [15:0] cmd;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    int ferr_pulses = 0;
    int ferr_base;
    bit timed_out;

    uart_cmd_assembler #(.TIMEOUT_CYCLES(200), .TO_W(18), .BAUD_DIV(BAUD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .trmt       (trmt),
        .resp       (resp),
        .tx_done    (tx_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Count consume strobes and error pulses; a strobe without a pending byte is an error
    always @(negedge clk) begin
        if (dut.clr_rx_rdy_c === 1'b1) begin
            clr_pulses++;
            checks++;
            assert (dut.rx_rdy === 1'b1) else begin
                errors++;
                $error("FAIL clr_without_rdy: observed rx_rdy=%0b expected 1", dut.rx_rdy);
            end
        end
        if (frame_err === 1'b1) ferr_pulses++;
    end

    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BAUD);
        end
        RX = 1'b1;
        tick(BAUD);
    endtask

    // Low byte with clr_cmd_rdy high across the completing edge; returns just after that edge
    task automatic send_byte_clr(input logic [7:0] b, output bit to);
        int n;
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BAUD);
        end
        RX = 1'b1;
        clr_cmd_rdy = 1'b1;
        n = 0;
        while (dut.clr_rx_rdy_c !== 1'b1 && n < 2 * BAUD) begin
            tick(1);
            n++;
        end
        to = (n >= 2 * BAUD);
        tick(1);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_tx_idle", 32'(TX), 32'h1);
        check("rst_tx_done", 32'(tx_done), 32'h0);
        rst_n = 1'b1;
        tick(2);

        send_byte(8'hA5);
        check("hi_no_rdy", 32'(cmd_rdy), 32'h0);
        check("clr_pulses_1", 32'(clr_pulses), 32'd1);
        send_byte(8'h3C);
        check("frame1_rdy", 32'(cmd_rdy), 32'h1);
        check("frame1_cmd", 32'(cmd), 32'hA53C);
        check("clr_pulses_2", 32'(clr_pulses), 32'd2);

        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("ack_clears_rdy", 32'(cmd_rdy), 32'h0);
        check("ack_keeps_cmd", 32'(cmd), 32'hA53C);
        tick(1);
        check("ack_stays_clear", 32'(cmd_rdy), 32'h0);

        send_byte(8'h12);
        check("hi2_no_rdy", 32'(cmd_rdy), 32'h0);
        check("hi2_cmd_held", 32'(cmd), 32'hA53C);
        send_byte_clr(8'h34, timed_out);
        check("lo2_wait_bound", 32'(timed_out), 32'h0);
        check("set_wins_rdy", 32'(cmd_rdy), 32'h1);
        check("frame2_cmd", 32'(cmd), 32'h1234);
        tick(1);
        check("rdy_holds", 32'(cmd_rdy), 32'h1);
        check("clr_pulses_4", 32'(clr_pulses), 32'd4);
        tick(BAUD);

        send_byte(8'hFF);
        check("hi_clears_rdy", 32'(cmd_rdy), 32'h0);
        check("hi_ff_cmd_held", 32'(cmd), 32'h1234);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("midrst_cmd", 32'(cmd), 32'h0);
        check("midrst_rdy", 32'(cmd_rdy), 32'h0);
        tick(2);
        send_byte(8'h01);
        send_byte(8'h02);
        check("post_rst_cmd", 32'(cmd), 32'h0102);
        check("post_rst_rdy", 32'(cmd_rdy), 32'h1);

        ferr_base = ferr_pulses;
        send_byte(8'h55);
        tick(260);
        check("timeout_ferr", 32'(ferr_pulses - ferr_base), 32'(EXP_FERR));
        send_byte(8'h0A);
        send_byte(8'h0B);
        check("after_to_cmd", 32'(cmd), 32'(EXP_CMD));
        check("after_to_rdy", 32'(cmd_rdy), 32'(EXP_RDY));

        resp = 8'hA5;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
        tick(8);
        check("tx_start", 32'(TX), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(BAUD);
            check($sformatf("tx_bit%0d", i), 32'(TX), 32'(resp[i]));
        end
        tick(BAUD);
        check("tx_stop", 32'(TX), 32'h1);
        check("tx_done_in_stop", 32'(tx_done), 32'h0);
        tick(7);
        check("tx_done_before_end", 32'(tx_done), 32'h0);
        tick(1);
        check("tx_done_at_end", 32'(tx_done), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
